// File: rtl/joy_poll_sched.sv
// rtl/joy_poll_sched.sv - polls two joysticks through a shared SPI engine once per period
// Unpacks 5-byte responses into registered axis/button values and strobes tick per round.
module joy_poll_sched #(
   parameter int POLL_DIV = 100000,
   parameter int TIMEOUT  = 4096
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        en,
   input  logic        spi_busy,
   output logic        spi_start,
   output logic        spi_sel,
   input  logic        spi_done,
   input  logic [39:0] spi_data,
   output logic [9:0]  joy0_x,
   output logic [9:0]  joy0_y,
   output logic [9:0]  joy1_x,
   output logic [9:0]  joy1_y,
   output logic [2:0]  joy0_btn,
   output logic [2:0]  joy1_btn,
   output logic        tick,
   output logic [1:0]  err,
   output logic        overrun
);

   localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(POLL_DIV - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_NEXT, S_DONE} state_t;

   state_t        state;
   logic [PW-1:0] pcnt;
   logic [TW-1:0] tcnt;
   logic          pending;
   logic          ch;
   logic          wrap;
   logic          take;
   logic [9:0]    new_x;
   logic [9:0]    new_y;
   logic [2:0]    new_btn;
   logic          unused_bits;

   assign wrap    = en && (pcnt == P_LAST);
   assign take    = (state == S_IDLE) && pending;
   assign new_x   = {spi_data[25:24], spi_data[39:32]};
   assign new_y   = {spi_data[9:8], spi_data[23:16]};
   assign new_btn = spi_data[2:0];
   assign unused_bits = ^{spi_data[31:26], spi_data[15:10], spi_data[7:3]};

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state     <= S_IDLE;
         pcnt      <= '0;
         tcnt      <= '0;
         pending   <= 1'b0;
         ch        <= 1'b0;
         spi_start <= 1'b0;
         spi_sel   <= 1'b0;
         tick      <= 1'b0;
         err       <= 2'b00;
         overrun   <= 1'b0;
         joy0_x    <= 10'd512;
         joy0_y    <= 10'd512;
         joy1_x    <= 10'd512;
         joy1_y    <= 10'd512;
         joy0_btn  <= 3'd0;
         joy1_btn  <= 3'd0;
      end else begin
         spi_start <= 1'b0;
         tick      <= 1'b0;

         if (en) begin
            if (pcnt == P_LAST) pcnt <= '0;
            else                pcnt <= pcnt + 1'b1;
         end

         // A round being consumed this edge frees the slot for a new one.
         if (wrap) begin
            if (pending && !take) overrun <= 1'b1;
            else                  pending <= 1'b1;
         end else if (take) begin
            pending <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               ch <= 1'b0;
               if (pending) begin
                  spi_sel <= 1'b0;
                  state   <= S_REQ;
               end
            end
            S_REQ: begin
               if (!spi_busy) begin
                  spi_start <= 1'b1;
                  tcnt      <= '0;
                  state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (spi_done) begin
                  if (ch) begin
                     joy1_x   <= new_x;
                     joy1_y   <= new_y;
                     joy1_btn <= new_btn;
                  end else begin
                     joy0_x   <= new_x;
                     joy0_y   <= new_y;
                     joy0_btn <= new_btn;
                  end
                  state <= S_NEXT;
               end else if (tcnt == T_LAST) begin
                  err[ch] <= 1'b1;
                  state   <= S_NEXT;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            S_NEXT: begin
               if (!ch) begin
                  ch      <= 1'b1;
                  spi_sel <= 1'b1;
                  state   <= S_REQ;
               end else begin
                  tick  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               ch    <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_joy_poll_sched.sv
// tb/tb_joy_poll_sched.sv - directed vector bench for joy_poll_sched
// Runs with POLL_DIV=64 and TIMEOUT=16; the SPI engine is emulated by the stimulus tasks.
module tb_joy_poll_sched;

   logic        clk;
   logic        clr;
   logic        en;
   logic        spi_busy;
   logic        spi_start;
   logic        spi_sel;
   logic        spi_done;
   logic [39:0] spi_data;
   logic [9:0]  joy0_x, joy0_y, joy1_x, joy1_y;
   logic [2:0]  joy0_btn, joy1_btn;
   logic        tick;
   logic [1:0]  err;
   logic        overrun;

   joy_poll_sched #(.POLL_DIV(64), .TIMEOUT(16)) dut (
      .clk(clk), .clr(clr), .en(en), .spi_busy(spi_busy),
      .spi_start(spi_start), .spi_sel(spi_sel), .spi_done(spi_done), .spi_data(spi_data),
      .joy0_x(joy0_x), .joy0_y(joy0_y), .joy1_x(joy1_x), .joy1_y(joy1_y),
      .joy0_btn(joy0_btn), .joy1_btn(joy1_btn), .tick(tick), .err(err), .overrun(overrun)
   );

   typedef struct {
      logic [39:0] d0;
      logic [39:0] d1;
      int x0, y0, b0, x1, y1, b1;
   } vec_t;

   vec_t vt[3];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   tick_cnt = 0;
   bit   bad_start;
   bit   bad_sel;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (tick === 1'b1) tick_cnt <= tick_cnt + 1;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic wait_start(output int t);
      int n;
      n = 0;
      while (spi_start !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) chk("start_wait_expired", 0, 1);
      t = cyc;
   endtask

   task automatic respond(input logic [39:0] d, input int dly);
      if (dly > 0) begin
         @(negedge clk);
         chk("start_one_cycle", spi_start, 0);
         repeat (dly - 1) @(negedge clk);
      end
      spi_data = d;
      spi_done = 1'b1;
      @(negedge clk);
      spi_done = 1'b0;
      spi_data = 40'h0;
   endtask

   task automatic ch_xfer(input logic [39:0] d, input int dly, input bit sel_exp,
                          input bit need_wait, output int t);
      if (need_wait) wait_start(t);
      else           t = cyc;
      chk("spi_sel", spi_sel, sel_exp);
      if (dly >= 0) respond(d, dly);
   endtask

   task automatic tick_check();
      chk("tick_before", tick, 0);
      @(negedge clk);
      chk("tick_pulse", tick, 1);
      @(negedge clk);
      chk("tick_after", tick, 0);
   endtask

   task automatic chk_joy0(input int x, input int y, input int b);
      chk("joy0_x", joy0_x, x);
      chk("joy0_y", joy0_y, y);
      chk("joy0_btn", joy0_btn, b);
   endtask

   task automatic chk_joy1(input int x, input int y, input int b);
      chk("joy1_x", joy1_x, x);
      chk("joy1_y", joy1_y, y);
      chk("joy1_btn", joy1_btn, b);
   endtask

   task automatic chk_reset_outputs();
      chk_joy0(512, 512, 0);
      chk_joy1(512, 512, 0);
      chk("rst_spi_start", spi_start, 0);
      chk("rst_spi_sel", spi_sel, 0);
      chk("rst_tick", tick, 0);
      chk("rst_err", err, 0);
      chk("rst_overrun", overrun, 0);
   endtask

   initial begin
      int t0, t1, prev, tc, sc;

      vt[0] = '{40'h3A_02_F0_01_05, 40'h00_00_FF_03_02, 570, 496, 5, 0, 1023, 2};
      vt[1] = '{40'hFF_FF_FF_FF_FF, 40'h55_FD_AA_FE_F8, 1023, 1023, 7, 341, 682, 0};
      vt[2] = '{40'h00_04_00_08_00, 40'h01_01_80_02_03, 0, 0, 0, 257, 640, 3};

      clr = 1'b1; en = 1'b0; spi_busy = 1'b0; spi_done = 1'b0; spi_data = 40'h0;
      repeat (3) @(negedge clk);
      chk_reset_outputs();
      clr = 1'b0;
      en  = 1'b1;

      // normal rounds from the vector table, one per period
      tc = tick_cnt;
      prev = 0;
      for (int r = 0; r < 3; r++) begin
         ch_xfer(vt[r].d0, 10, 1'b0, 1'b1, t0);
         chk_joy0(vt[r].x0, vt[r].y0, vt[r].b0);
         ch_xfer(vt[r].d1, 10, 1'b1, 1'b1, t1);
         tick_check();
         chk_joy1(vt[r].x1, vt[r].y1, vt[r].b1);
         if (r > 0) chk("round_period", t0 - prev, 64);
         prev = t0;
      end
      chk("ticks_per_3_periods", tick_cnt - tc, 3);
      chk("err_after_normal", err, 0);

      // busy hold over the next round start
      spi_busy = 1'b1;
      bad_start = 1'b0;
      bad_sel = 1'b0;
      while (cyc < prev + 94) begin
         @(negedge clk);
         if (spi_start) bad_start = 1'b1;
         if (cyc >= prev + 63 && spi_sel !== 1'b0) bad_sel = 1'b1;
      end
      chk("busy_no_start", bad_start, 0);
      chk("busy_sel_held", bad_sel, 0);
      spi_busy = 1'b0;
      @(negedge clk);
      chk("busy_release_start", spi_start, 1);
      ch_xfer(40'h12_03_34_00_06, 5, 1'b0, 1'b0, t0);
      chk_joy0(786, 52, 6);
      ch_xfer(40'h9A_01_BC_02_01, 5, 1'b1, 1'b1, t1);
      tick_check();
      chk_joy1(410, 700, 1);
      chk("busy_err", err, 0);
      chk("busy_overrun", overrun, 0);

      // channel 1 never answers
      ch_xfer(40'h00_00_00_00_00, 3, 1'b0, 1'b1, t0);
      ch_xfer(40'h0, -1, 1'b1, 1'b1, t1);
      repeat (15) @(negedge clk);
      chk("timeout_err_early", err, 0);
      @(negedge clk);
      chk("timeout_err_set", err, 2);
      tick_check();
      chk_joy0(0, 0, 0);
      chk_joy1(410, 700, 1);

      // done arrives on the last timeout cycle
      ch_xfer(40'h7F_01_7F_01_04, 15, 1'b0, 1'b1, sc);
      chk("collide_err_ch0", err, 2);
      chk_joy0(383, 383, 4);
      ch_xfer(40'h20_03_40_02_07, 15, 1'b1, 1'b1, t1);
      tick_check();
      chk("collide_err_ch1", err, 2);
      chk_joy1(800, 576, 7);

      // stall rounds so periods pile up
      spi_busy = 1'b1;
      while (cyc < sc + 150) @(negedge clk);
      chk("overrun_not_yet", overrun, 0);
      while (cyc < sc + 193) @(negedge clk);
      chk("overrun_set", overrun, 1);
      spi_busy = 1'b0;
      ch_xfer(40'h11_00_22_00_01, 2, 1'b0, 1'b1, t0);
      ch_xfer(40'h33_00_44_00_02, 2, 1'b1, 1'b1, t1);
      tick_check();
      chk_joy0(17, 34, 1);
      chk_joy1(51, 68, 2);
      wait_start(t0);
      chk("pending_served_quickly", (t0 - t1) < 12, 1);
      en = 1'b0;
      ch_xfer(40'h00_02_00_01_03, 2, 1'b0, 1'b0, t0);
      ch_xfer(40'h05_03_06_03_04, 2, 1'b1, 1'b1, t1);
      tick_check();
      chk_joy0(512, 256, 3);
      chk_joy1(773, 774, 4);
      bad_start = 1'b0;
      repeat (200) @(negedge clk);
      chk("en_low_no_start", bad_start, 0);
      repeat (1) begin
         bad_start = 1'b0;
      end
      chk("overrun_sticky", overrun, 1);

      // reset in the middle of WAIT
      en = 1'b1;
      wait_start(t0);
      repeat (3) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      chk_reset_outputs();
      clr = 1'b0;
      tc = tick_cnt;
      respond(40'hFF_FF_FF_FF_FF, 1);
      chk("post_clr_joy0_x", joy0_x, 512);
      chk("post_clr_joy0_btn", joy0_btn, 0);
      bad_start = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (spi_start) bad_start = 1'b1;
      end
      chk("post_clr_no_start", bad_start, 0);
      chk("post_clr_no_tick", tick_cnt - tc, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   always @(negedge clk) if (!en && spi_start === 1'b1 && cyc > 0) bad_start = 1'b1;

endmodule

// File: doc/joy_poll_sched.md
# joy_poll_sched

- Periodically sequences one shared SPI transaction engine across the two joystick channels, channel 0 (player 1) then channel 1 (player 2).
- Unpacks each 5-byte joystick response into registered 10-bit X/Y and 3-bit button values, then pulses a cursor tick once per completed round.
- Sits between the SPI master and the per-player cursor-update logic, which consume `joyN_x/joyN_y` and use `tick` as their movement strobe.

## Interface

Parameters:
- `POLL_DIV`, default 100000: clk cycles between round starts (≥ 4).
- `TIMEOUT`, default 4096: clk cycles to wait for `spi_done` before abandoning a transaction (≥ 2).

Ports:
- `clk` in 1: system clock.
- `clr` in 1: reset, asynchronous, active-high.
- `en` in 1: polling enable.
- `spi_busy` in 1: SPI engine busy.
- `spi_start` out 1: one-cycle transaction start pulse.
- `spi_sel` out 1: addressed channel (0 = joystick 0, 1 = joystick 1); stable from `spi_start` until done/timeout.
- `spi_done` in 1: one-cycle completion pulse from SPI engine.
- `spi_data` in 40: response bytes B0..B4 = `[39:32]`,`[31:24]`,`[23:16]`,`[15:8]`,`[7:0]`.
- `joy0_x`, `joy0_y`, `joy1_x`, `joy1_y` out 10: latched axis values.
- `joy0_btn`, `joy1_btn` out 3: latched buttons.
- `tick` out 1: one-cycle pulse at round end.
- `err` out 2: sticky per-channel timeout flags.
- `overrun` out 1: sticky, set when a period elapses while a round is already pending.

## Operation

Unpack rule:
- x = {B1[1:0], B0}.
- y = {B3[1:0], B2}.
- btn = B4[2:0].
- Other bits are ignored.

Period counter:
- `pcnt` runs 0..POLL_DIV-1 and wraps. It counts while `en`=1 and holds its value while `en`=0.
- On wrap, with `en`=1: if `pending`=0, set `pending`. If `pending` is already 1, set `overrun` and drop the event; at most one round is ever pending.

State machine: IDLE, REQ, WAIT, NEXT, DONE.
- IDLE: `ch`=0. If `pending` → REQ and clear `pending`.
- REQ: drive `spi_sel`=`ch`. If `spi_busy`=0 → pulse `spi_start` (registered, high exactly one cycle), clear the timeout counter, go to WAIT. If `spi_busy`=1, stay in REQ indefinitely; the timeout does not run in REQ.
- WAIT:
  - If `spi_done`=1, latch unpacked `spi_data` into channel `ch` outputs → NEXT.
  - Else if the timeout counter reaches TIMEOUT-1, set `err[ch]` and keep the old values → NEXT.
  - Otherwise the counter increments.
- NEXT: if `ch`=0, set `ch`=1 → REQ. If `ch`=1 → DONE.
- DONE: pulse `tick` → IDLE.

Boundary and corner cases:
- `spi_done` and timeout in the same cycle: done wins; no error is set.
- `spi_done` outside WAIT is ignored.
- `en` falling mid-round: the current round completes, including `tick`; no new `pending` is set. `pending` already set before `en` fell is still served.
- `err` and `overrun` clear only on `clr`.
- `clr` mid-round: everything returns to reset immediately. The SPI engine may still complete; its `spi_done` is ignored because the FSM is in IDLE.

Reset values:
- `joyN_x` = `joyN_y` = 512 (centre).
- `joyN_btn` = 0, `spi_start` = 0, `spi_sel` = 0, `tick` = 0, `err` = 0, `overrun` = 0.
- `pcnt` = 0, `pending` = 0, state IDLE.

## Timing

- All outputs are registered; there are no combinational paths from inputs to outputs.
- `pending` is set at the clock edge where `pcnt` = POLL_DIV-1. IDLE→REQ follows one edge later. With `spi_busy`=0, `spi_start` is high on the next cycle.
- `spi_done` sampled high at edge k → the new `joyN_*` values are visible from cycle k+1.
- Channel 0 done → channel 1 `spi_start` 2 cycles later (NEXT, REQ), if not busy.
- Channel 1 done/timeout at edge k → `tick` high during cycle k+2 only. `joy1_*` already shows the new value when `tick` is high.
- Timeout: `spi_start` cycle t → `err` set at t+TIMEOUT.
- Minimum round with immediate `spi_done`: about 8 cycles, which must be < POLL_DIV.

## Test plan

1. **Reset:** assert `clr` mid-WAIT → all outputs at reset values next cycle; a later `spi_done` produces no update and no `tick`.
2. **Normal round:** POLL_DIV=64. Channel 0 `spi_data`=40'h3A_02_F0_01_05, channel 1 = 40'h00_00_FF_03_02, `spi_done` 10 cycles after each start → `joy0_x`=570, `joy0_y`=496, `joy0_btn`=5, `joy1_x`=0, `joy1_y`=1023, `joy1_btn`=2. `tick` is a single pulse, exactly one per 64-cycle period.
3. **Busy hold:** `spi_busy`=1 for 30 cycles at round start → `spi_start` stays low, `spi_sel`=0 is held, and `spi_start` fires the cycle after `spi_busy` falls; `err`=0.
4. **Timeout:** TIMEOUT=16, no `spi_done` on channel 1 → `err`=2'b10 at start+16, `joy1_*` unchanged, channel 0 updated, `tick` still pulses.
5. **Done/timeout collision:** `spi_done` in the cycle the counter hits TIMEOUT-1 → data latched and `err` stays 0.
6. **Overrun and enable:** POLL_DIV=8 with slow `spi_done` → `overrun`=1 and one pending round is served. Drop `en` mid-round → that round's `tick` occurs, then no further `spi_start`.
